// File: rtl/range_ctrl_pkg.sv
// range_ctrl_pkg: shared types and widths for the Collatz range controller.
// Exports state_t, N_BITS, CNT_BITS and disp_bits().
package range_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    BROWSE,
    ERR
  } state_t;

  localparam int N_BITS   = 32;
  localparam int CNT_BITS = 16;

  // base + index needs one carry bit over the wider operand; a second
  // spare bit leaves room for a wider switch field without a port change.
  function automatic int disp_bits(input int sw_bits, input int idx_bits);
    int w;
    w = (sw_bits > idx_bits) ? sw_bits : idx_bits;
    return w + 2;
  endfunction

endpackage

// File: rtl/read_lat_timer.sv
// read_lat_timer: latency-matched read strobe for a fixed-latency memory.
// Ports: clk, reset (sync, high), start (load LAT), fire (data valid now).
module read_lat_timer #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic fire
);

  localparam int W = $clog2(LAT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= W'(LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // fire on the edge where the counter reaches 0, so the consumer
  // latches the data exactly LAT edges after the read started
  assign fire = (cnt == W'(1));

endmodule

// File: rtl/range_ctrl.sv
// range_ctrl: launches a Collatz range run, watchdogs it, then browses results.
// Ports: clk/reset, sw_start, go/add/sub/home pulses, range_* engine bus, status and display.
module range_ctrl
  import range_ctrl_pkg::*;
#(
  parameter int RAM_WORDS     = 256,
  parameter int RAM_ADDR_BITS = 8,
  parameter int READ_LAT      = 2,
  parameter int TIMEOUT       = 16_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          sw_start,
  input  logic                go_req,
  input  logic                add_pulse,
  input  logic                sub_pulse,
  input  logic                home_pulse,
  output logic                range_go,
  output logic [N_BITS-1:0]   range_start,
  input  logic                range_done,
  input  logic [CNT_BITS-1:0] range_count,
  output logic                busy,
  output logic                ready,
  output logic                err,
  output logic [11:0]         disp_n,
  output logic [CNT_BITS-1:0] disp_count,
  output logic                count_valid
);

  localparam int DISP_BITS = disp_bits(10, RAM_ADDR_BITS);
  localparam int WD_BITS   = $clog2(TIMEOUT);

  localparam logic [RAM_ADDR_BITS-1:0] IDX_MAX =
    RAM_ADDR_BITS'(RAM_WORDS - 1);
  // leaving WAIT on this value makes the counter land on TIMEOUT-1
  localparam logic [WD_BITS-1:0] WD_LAST = WD_BITS'(TIMEOUT - 2);

  state_t                   state;
  state_t                   next_state;
  logic [9:0]               base;
  logic [RAM_ADDR_BITS-1:0] index;
  logic [RAM_ADDR_BITS-1:0] idx_nxt;
  logic [WD_BITS-1:0]       wd;
  logic                     rd;
  logic                     rd_fire;
  logic [DISP_BITS-1:0]     sum;

  read_lat_timer #(
    .LAT(READ_LAT)
  ) u_lat (
    .clk  (clk),
    .reset(reset),
    .start(rd),
    .fire (rd_fire)
  );

  always_comb begin
    next_state  = state;
    idx_nxt     = index;
    rd          = 1'b0;
    range_go    = 1'b0;
    range_start = '0;
    busy        = 1'b0;
    ready       = 1'b0;
    err         = 1'b0;
    unique case (state)
      IDLE: begin
        if (go_req) next_state = LAUNCH;
      end
      LAUNCH: begin
        range_go    = 1'b1;
        range_start = N_BITS'(sw_start);
        busy        = 1'b1;
        next_state  = WAIT;
      end
      WAIT: begin
        range_start = N_BITS'(base);
        busy        = 1'b1;
        if (range_done) begin
          next_state = BROWSE;
          idx_nxt    = '0;
          rd         = 1'b1;
        end else if (wd == WD_LAST) begin
          next_state = ERR;
        end
      end
      ERR: begin
        err = 1'b1;
        if (go_req) next_state = LAUNCH;
      end
      BROWSE: begin
        ready       = 1'b1;
        range_start = N_BITS'(index);
        if (go_req) begin
          next_state = LAUNCH;
        end else if (home_pulse) begin
          if (index != '0) begin
            idx_nxt = '0;
            rd      = 1'b1;
          end
        end else if (add_pulse && !sub_pulse) begin
          if (index != IDX_MAX) begin
            idx_nxt = index + 1'b1;
            rd      = 1'b1;
          end
        end else if (sub_pulse && !add_pulse) begin
          if (index != '0) begin
            idx_nxt = index - 1'b1;
            rd      = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      index       <= '0;
      wd          <= '0;
      disp_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      state <= next_state;
      index <= idx_nxt;
      if (state == LAUNCH) begin
        base <= sw_start;
        wd   <= '0;
      end else if (state == WAIT) begin
        wd <= wd + 1'b1;
      end
      // a stale timer fire from abandoned results must not set valid
      if (next_state == LAUNCH || rd) begin
        count_valid <= 1'b0;
      end else if (rd_fire && state == BROWSE) begin
        disp_count  <= range_count;
        count_valid <= 1'b1;
      end
    end
  end

  assign sum    = DISP_BITS'(base) + DISP_BITS'(index);
  assign disp_n = 12'(sum);

endmodule

// File: tb/tb_range_ctrl.sv
// tb_range_ctrl: vector table, hand sequences and random browsing
// against a time-based reference model of the range controller.
module tb_range_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  sw_start = '0;
  logic        go_req = 1'b0;
  logic        add_pulse = 1'b0;
  logic        sub_pulse = 1'b0;
  logic        home_pulse = 1'b0;
  logic        range_go;
  logic [31:0] range_start;
  logic        range_done = 1'b0;
  logic [15:0] range_count = '0;
  logic        busy;
  logic        ready;
  logic        err;
  logic [11:0] disp_n;
  logic [15:0] disp_count;
  logic        count_valid;

  localparam int LAT = 2;

  range_ctrl #(
    .RAM_WORDS    (256),
    .RAM_ADDR_BITS(8),
    .READ_LAT     (LAT),
    .TIMEOUT      (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_start   (sw_start),
    .go_req     (go_req),
    .add_pulse  (add_pulse),
    .sub_pulse  (sub_pulse),
    .home_pulse (home_pulse),
    .range_go   (range_go),
    .range_start(range_start),
    .range_done (range_done),
    .range_count(range_count),
    .busy       (busy),
    .ready      (ready),
    .err        (err),
    .disp_n     (disp_n),
    .disp_count (disp_count),
    .count_valid(count_valid)
  );

  always #10 clk = ~clk;

  logic [15:0] mem [256];

  always @(posedge clk) range_count <= mem[range_start[7:0]];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic launch(input logic [9:0] n);
    sw_start = n;
    go_req   = 1'b1;
    tick();
    go_req   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ready"}, ready, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " range_go"}, range_go, 0);
    chk({tag, " range_start"}, range_start, 0);
    chk({tag, " disp_n"}, disp_n, 0);
    chk({tag, " disp_count"}, disp_count, 0);
    chk({tag, " count_valid"}, count_valid, 0);
  endtask

  typedef struct {
    logic a;
    logic s;
    logic h;
    int   idx;
    logic rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int midx;
    int ecnt;
    int lrd;
    int laddr;

    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 0, 1'b1};

    // low byte = address keeps every word distinct
    for (int i = 0; i < 256; i++)
      mem[i] = {8'($urandom_range(0, 255)), 8'(i)};

    @(negedge clk);
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // launch from 27
    launch(10'd27);
    chk("launch range_go", range_go, 1);
    chk("launch range_start", range_start, 27);
    chk("launch busy", busy, 1);
    chk("launch ready", ready, 0);
    tick();
    chk("wait range_go", range_go, 0);
    chk("wait range_start", range_start, 27);
    chk("wait busy", busy, 1);
    tick();
    tick();
    range_done = 1'b1;
    tick();
    range_done = 1'b0;
    chk("done ready", ready, 1);
    chk("done busy", busy, 0);
    chk("done range_start", range_start, 0);
    chk("done disp_n", disp_n, 27);
    chk("done cv", count_valid, 0);
    tick();
    chk("done+1 cv", count_valid, 0);
    tick();
    chk("done+2 cv", count_valid, 1);
    chk("done+2 disp_count", disp_count, mem[0]);

    // table of browse pulses
    for (int i = 0; i < 11; i++) begin
      add_pulse  = tbl[i].a;
      sub_pulse  = tbl[i].s;
      home_pulse = tbl[i].h;
      tick();
      add_pulse  = 1'b0;
      sub_pulse  = 1'b0;
      home_pulse = 1'b0;
      chk($sformatf("tbl%0d range_start", i), range_start, tbl[i].idx);
      chk($sformatf("tbl%0d disp_n", i), disp_n, 27 + tbl[i].idx);
      chk($sformatf("tbl%0d cv", i), count_valid, tbl[i].rd ? 0 : 1);
      tick();
      tick();
      chk($sformatf("tbl%0d cv settled", i), count_valid, 1);
      chk($sformatf("tbl%0d disp_count", i), disp_count, mem[tbl[i].idx]);
    end

    // walk to the top and saturate
    add_pulse = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    add_pulse = 1'b0;
    tick();
    tick();
    chk("top range_start", range_start, 255);
    chk("top disp_n", disp_n, 27 + 255);
    chk("top cv", count_valid, 1);
    add_pulse = 1'b1;
    tick();
    add_pulse = 1'b0;
    chk("sat range_start", range_start, 255);
    chk("sat disp_n", disp_n, 282);
    chk("sat cv", count_valid, 1);
    chk("sat disp_count", disp_count, mem[255]);
    tick();
    chk("sat+1 cv", count_valid, 1);

    // two adds one cycle apart: only index 2 lands
    home_pulse = 1'b1;
    tick();
    home_pulse = 1'b0;
    tick();
    tick();
    add_pulse = 1'b1;
    tick();
    add_pulse = 1'b0;
    chk("aa e0 cv", count_valid, 0);
    tick();
    chk("aa e1 cv", count_valid, 0);
    add_pulse = 1'b1;
    tick();
    add_pulse = 1'b0;
    chk("aa e2 cv", count_valid, 0);
    chk("aa e2 range_start", range_start, 2);
    tick();
    chk("aa e3 cv", count_valid, 0);
    tick();
    chk("aa e4 cv", count_valid, 1);
    chk("aa e4 disp_count", disp_count, mem[2]);

    // random browsing vs. time-based model
    midx  = 2;
    laddr = 2;
    ecnt  = 0;
    lrd   = -100;
    for (int i = 0; i < 400; i++) begin
      int  r;
      logic rdv;
      r   = $urandom_range(0, 9);
      rdv = 1'b0;
      add_pulse  = (r == 0 || r == 1 || r == 4);
      sub_pulse  = (r == 2 || r == 4);
      home_pulse = (r == 3);
      range_done = (r == 5);
      if (home_pulse) begin
        if (midx != 0) begin
          midx = 0;
          rdv  = 1'b1;
        end
      end else if (add_pulse && !sub_pulse) begin
        if (midx < 255) begin
          midx++;
          rdv = 1'b1;
        end
      end else if (sub_pulse && !add_pulse) begin
        if (midx > 0) begin
          midx--;
          rdv = 1'b1;
        end
      end
      tick();
      add_pulse  = 1'b0;
      sub_pulse  = 1'b0;
      home_pulse = 1'b0;
      range_done = 1'b0;
      ecnt++;
      if (rdv) begin
        lrd   = ecnt;
        laddr = midx;
      end
      chk("rnd range_start", range_start, midx);
      chk("rnd disp_n", disp_n, 27 + midx);
      chk("rnd ready", ready, 1);
      chk("rnd cv", count_valid, (ecnt - lrd >= LAT) ? 1 : 0);
      if (ecnt - lrd >= LAT)
        chk("rnd disp_count", disp_count, mem[laddr]);
    end

    // reset in the middle of a run
    launch(10'd5);
    tick();
    chk("midwait busy", busy, 1);
    reset      = 1'b1;
    range_done = 1'b1;
    tick();
    chk_all_zero("midreset");
    reset = 1'b0;
    tick();
    range_done = 1'b0;
    chk("post-reset range_go", range_go, 0);
    chk("post-reset ready", ready, 0);
    chk("post-reset busy", busy, 0);

    // watchdog
    launch(10'd100);
    for (int i = 0; i < 99; i++) tick();
    chk("wd99 err", err, 0);
    chk("wd99 busy", busy, 1);
    tick();
    chk("wd100 err", err, 1);
    chk("wd100 busy", busy, 0);
    tick();
    chk("wd101 err", err, 1);
    launch(10'd9);
    chk("relaunch err", err, 0);
    chk("relaunch range_go", range_go, 1);
    chk("relaunch range_start", range_start, 9);
    tick();
    range_done = 1'b1;
    tick();
    range_done = 1'b0;
    chk("relaunch ready", ready, 1);
    chk("relaunch disp_n", disp_n, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/range_ctrl.md
Name: range_ctrl

Overview:
- Sequencing controller for the Collatz range engine. It launches a range run from the switch value and waits for completion with a watchdog.
- After the run it owns the engine's start/address bus for browsing results. It steps a result index from button pulses, issues reads and latches the returned count for display.
- It sits between the debounced/typematic button pulses and the range engine in the lab1 top level, replacing the ad-hoc always_ff there.

Parameters:
- RAM_WORDS, 256, number of results one range run produces.
- RAM_ADDR_BITS, 8, index width; clog2(RAM_WORDS).
- READ_LAT, 2, cycles from address change to valid range_count.
- TIMEOUT, 16_000_000, cycles in WAIT without range_done before error.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- sw_start  in  10  starting n, from SW.
- go_req  in  1  single-cycle pulse: launch a run.
- add_pulse  in  1  single-cycle pulse: index + 1.
- sub_pulse  in  1  single-cycle pulse: index - 1.
- home_pulse  in  1  single-cycle pulse: index to 0.
- range_go  out  1  one-cycle start strobe to the range engine.
- range_start  out  32  start value during launch; read address while browsing.
- range_done  in  1  engine completion pulse or level.
- range_count  in  16  engine read data.
- busy  out  1  run in progress.
- ready  out  1  results browsable.
- err  out  1  watchdog expired.
- disp_n  out  12  n currently shown: base + index.
- disp_count  out  16  latched iteration count for disp_n.
- count_valid  out  1  disp_count matches disp_n.

Behaviour:
- Reset: state IDLE. Every output is 0, including base, index and the watchdog counter. Reset has priority over every input in every state, including mid-run.
- States: IDLE, LAUNCH, WAIT, BROWSE, ERR.
- IDLE:
  - range_go = 0.
  - go_req -> LAUNCH.
- LAUNCH, exactly one cycle:
  - base <= sw_start.
  - range_start = zero-extended sw_start.
  - range_go = 1.
  - busy = 1; ready, err and count_valid = 0.
  - Next state WAIT.
- WAIT:
  - range_start holds base; range_go = 0; busy = 1.
  - The watchdog increments every cycle. go_req, add, sub and home are ignored.
  - range_done -> BROWSE, with index <= 0 and a read started, in that same cycle.
  - Watchdog reaching TIMEOUT-1 without done -> ERR.
- ERR:
  - err = 1; busy = 0.
  - go_req -> LAUNCH, which clears err.
- BROWSE:
  - ready = 1.
  - range_start = zero-extended index.
  - disp_n = base + index, 12-bit. Maximum is 1023 + 255 = 1278, so no overflow.
- BROWSE input priority per cycle: go_req > home_pulse > add/sub.
  - go_req -> LAUNCH with a new base. The old results are abandoned.
  - home_pulse with index != 0 -> index <= 0 and start a read.
  - add_pulse and sub_pulse in the same cycle -> no action.
  - add with index < RAM_WORDS-1 -> index + 1 and start a read. At RAM_WORDS-1 the index saturates, no read starts and count_valid is unchanged.
  - sub with index > 0 -> index - 1 and start a read. At 0 the index saturates, with no read.
- Read start:
  - count_valid <= 0 and the latency counter loads READ_LAT.
  - The counter decrements each cycle. When it reaches 0, disp_count <= range_count and count_valid <= 1.
  - A new read while one is pending restarts the counter. Only the latest address is latched.
- disp_count is held across LAUNCH and WAIT, but count_valid is 0 there. It is cleared to 0 only by reset.
- range_done outside WAIT is ignored.

Decomposition:
- range_ctrl_pkg holds:
  - state_t, the enum IDLE/LAUNCH/WAIT/BROWSE/ERR;
  - the N_BITS = 32 and CNT_BITS = 16 constants;
  - a function computing disp_n width.
- One sub-module, read_lat_timer, takes params LAT; ports clk, reset, start, fire. It does the load/decrement/fire logic and is reused for any future latency-matched reads.
- The watchdog stays inline.

Test Plan:
- Reset mid-WAIT, with busy = 1 -> next cycle all outputs 0, state IDLE, range_go stays 0 even if range_done arrives.
- sw_start = 27, go_req -> range_go high exactly one cycle with range_start = 27. busy = 1 until range_done. Then ready = 1, range_start = 0, disp_n = 27, and count_valid rises READ_LAT cycles after done with disp_count equal to mem[0].
- In BROWSE: 3 add pulses -> index 3, disp_n = 30, range_start = 3. Then home -> index 0. Then sub at 0 -> no change, no read.
- Index 255 plus add -> stays 255, disp_n = base + 255, and count_valid stays 1.
- add and sub in the same cycle -> no change. Two adds 1 cycle apart -> only the index-2 data is latched, and count_valid is low in between.
- TIMEOUT = 100 with no range_done -> err = 1 at cycle 100 after LAUNCH, busy = 0. A following go_req clears err and relaunches.
